// File: rtl/frame_out_pkg.sv
// Shared types and helpers for the frame output buffer.
package frame_out_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   localparam int DEF_IMG_W = 256;
   localparam int DEF_IMG_H = 256;
   localparam int FRAME_PIX = DEF_IMG_W * DEF_IMG_H;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small circular FIFO with combinational head read; caller never pushes when full or pops when empty.
module stream_fifo
   import frame_out_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   output logic              full,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              empty
);

   localparam int PTR_W = clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: contents are only visible while count is nonzero.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= din;
   end

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign dout  = mem_q[rd_ptr_q];

endmodule

// File: rtl/frame_out_buffer.sv
// Output stream stage: buffers datapath pixels, tags end-of-line/frame and signals frame completion.
module frame_out_buffer
   import frame_out_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int IMG_W  = DEF_IMG_W,
   parameter int IMG_H  = DEF_IMG_H,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] data_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              eol_out,
   output logic              eof_out,
   output logic              stop_out
);

   localparam int TOT   = IMG_W * IMG_H;
   localparam int CNT_W = clog2(TOT + 1);
   localparam int COL_W = (IMG_W > 1) ? clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? clog2(IMG_H) : 1;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic              stop_q, stop_d;
   logic              fifo_full, fifo_empty, push, pop, last_col, last_row;

   // in_ready looks only at registered state, so there is no path from out_ready.
   assign in_ready  = (state_q == RUN) && !fifo_full && (in_cnt_q < CNT_W'(TOT));
   assign push      = in_valid && in_ready;
   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   assign last_col  = (col_q == COL_W'(IMG_W - 1));
   assign last_row  = (row_q == ROW_W'(IMG_H - 1));
   assign eol_out   = out_valid && last_col;
   assign eof_out   = eol_out && last_row;
   assign stop_out  = stop_q;

   stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (data_in),
      .full  (fifo_full),
      .pop   (pop),
      .dout  (data_out),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d  = state_q;
      in_cnt_d = in_cnt_q;
      col_d    = col_q;
      row_d    = row_q;
      stop_d   = stop_q;
      if (push) in_cnt_d = in_cnt_q + CNT_W'(1);
      if (pop) begin
         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + ROW_W'(1);
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end
      case (state_q)
         IDLE, DONE: begin
            if (start_in) begin
               state_d  = RUN;
               in_cnt_d = '0;
               col_d    = '0;
               row_d    = '0;
               stop_d   = 1'b0;
            end
         end
         RUN: begin
            if (push && in_cnt_q == CNT_W'(TOT - 1)) state_d = DRAIN;
         end
         DRAIN: begin
            if (pop && eof_out) begin
               state_d = DONE;
               stop_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         in_cnt_q <= '0;
         col_q    <= '0;
         row_q    <= '0;
         stop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         in_cnt_q <= in_cnt_d;
         col_q    <= col_d;
         row_q    <= row_d;
         stop_q   <= stop_d;
      end
   end

endmodule

// File: tb/tb_frame_out_buffer.sv
// Randomized bench for frame_out_buffer against a queue-based frame model.
module tb_frame_out_buffer;

   localparam int W   = 16;
   localparam int H   = 8;
   localparam int D   = 4;
   localparam int TOT = W * H;
   localparam int BUDGET = 8000;

   logic       clk = 1'b0;
   logic       reset, start_in, in_valid, out_ready;
   logic [7:0] data_in, data_out;
   logic       in_ready, out_valid, eol_out, eof_out, stop_out;

   always #5 clk = ~clk;

   frame_out_buffer #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .DEPTH(D)) dut (
      .clk       (clk),
      .reset     (reset),
      .start_in  (start_in),
      .data_in   (data_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_out  (data_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .eol_out   (eol_out),
      .eof_out   (eof_out),
      .stop_out  (stop_out)
   );

   int         checks = 0;
   int         failures = 0;
   logic [7:0] q[$];
   int         push_cnt, pop_cnt;
   bit         started;
   logic [7:0] dxor;
   int         stall;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      q.delete();
      push_cnt = 0;
      pop_cnt  = 0;
      started  = 0;
   endtask

   // One clock: drive, check at negedge, then advance the model after the edge.
   task automatic step(input bit st, input bit iv, input bit ordy);
      bit ir, push, pop, acc;
      start_in = st;
      in_valid = iv;
      out_ready = ordy;
      data_in = 8'(push_cnt) ^ dxor;
      @(negedge clk);
      ir = started && push_cnt < TOT && q.size() < D;
      chk("in_ready", in_ready, ir);
      chk("out_valid", out_valid, q.size() != 0);
      chk("eol", eol_out, q.size() != 0 && (pop_cnt % W) == W - 1);
      chk("eof", eof_out, q.size() != 0 && pop_cnt == TOT - 1);
      chk("stop", stop_out, started && pop_cnt == TOT);
      if (q.size() != 0) chk("data", data_out, q[0]);
      push = iv && ir;
      pop  = ordy && q.size() != 0;
      acc  = st && (!started || pop_cnt == TOT);
      @(posedge clk);
      #1;
      if (pop) begin
         void'(q.pop_front());
         pop_cnt++;
      end
      if (push) begin
         q.push_back(data_in);
         push_cnt++;
      end
      if (acc) begin
         q.delete();
         push_cnt = 0;
         pop_cnt  = 0;
         started  = 1;
      end
   endtask

   task automatic rand_step();
      bit ordy;
      if (stall > 0) begin
         stall--;
         ordy = 0;
      end else if ($urandom_range(0, 15) == 0) begin
         stall = $urandom_range(1, 32);
         ordy = 0;
      end else begin
         ordy = 1'($urandom_range(0, 1));
      end
      step($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), ordy);
   endtask

   task automatic run_to_done(input string tag, input bit rnd);
      int n;
      n = 0;
      stall = 0;
      while (pop_cnt < TOT && n < BUDGET) begin
         if (rnd) rand_step();
         else step(0, 1, 1);
         n++;
      end
      chk(tag, pop_cnt, TOT);
      step(0, 1, 1);
      chk({tag, "_stop"}, stop_out, 1'b1);
   endtask

   task automatic hard_reset();
      reset = 1;
      start_in = 0;
      in_valid = 0;
      out_ready = 0;
      @(posedge clk);
      #1;
      reset = 0;
      model_clear();
   endtask

   initial begin
      reset = 1;
      start_in = 0;
      in_valid = 0;
      out_ready = 0;
      data_in = '0;
      dxor = '0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_eol", eol_out, 1'b0);
      chk("rst_eof", eof_out, 1'b0);
      chk("rst_stop", stop_out, 1'b0);

      // Full-rate frame, data = index
      step(1, 0, 1);
      run_to_done("frame_seq", 0);

      // Back-pressure: only DEPTH pixels get in while the sink stalls
      dxor = 8'($urandom);
      step(1, 0, 1);
      repeat (20) step(0, 1, 0);
      chk("bp_accepted", push_cnt, D);
      run_to_done("frame_bp", 0);

      // Random valid/ready with stalls and stray start pulses
      dxor = 8'($urandom);
      step(1, 0, 1);
      run_to_done("frame_rand", 1);

      // Input held after frame end: nothing more accepted or emitted
      repeat (10) step(0, 1, 1);
      chk("no_extra_push", push_cnt, TOT);
      chk("no_extra_pop", pop_cnt, TOT);

      // Mid-frame reset with pixels buffered
      dxor = 8'($urandom);
      step(1, 0, 1);
      for (int n = 0; n < 200 && push_cnt < 50; n++) step(0, 1, 1);
      for (int n = 0; n < 10 && q.size() < 3; n++) step(0, q.size() < 3, 0);
      chk("buffered", q.size(), 3);
      hard_reset();
      chk("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_in_ready", in_ready, 1'b0);
      chk("mid_rst_stop", stop_out, 1'b0);
      step(0, 1, 1);
      dxor = 8'($urandom);
      step(1, 0, 1);
      run_to_done("frame_after_rst", 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
